// File: rtl/mem_responder.sv
// Single-outstanding memory responder: valid/ready request, WAIT_CYC wait states, held response.
// Optional MEM_RESPONDER_STATS_EN adds saturating read/write response counters.
module mem_responder #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata
`ifdef MEM_RESPONDER_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LIM_W = ADDR_W + 1;
  localparam logic [LIM_W-1:0] DepthLim = LIM_W'(DEPTH);
  localparam logic [3:0] WaitLd = 4'(WAIT_CYC);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_d;

  logic              accept;
  logic              access;
  logic              acc_write;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [IDX_W-1:0]  acc_idx;
  logic              in_range;

  logic [DATA_W-1:0] mem [DEPTH];

  assign req_ready = (state_q == StIdle) && rst_n;
  assign accept    = req_valid && req_ready;

  // With zero wait states the access uses the request fields on the accept edge itself.
  assign acc_write = (state_q == StIdle) ? req_write : wr_q;
  assign acc_addr  = (state_q == StIdle) ? req_addr  : addr_q;
  assign acc_wdata = (state_q == StIdle) ? req_wdata : wdata_q;
  assign acc_idx   = acc_addr[IDX_W-1:0];
  assign in_range  = {1'b0, acc_addr} < DepthLim;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    access      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYC == 0) begin
            access  = 1'b1;
            state_d = StResp;
          end else begin
            cnt_d   = WaitLd;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          access  = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (access) begin
      rsp_valid_d = 1'b1;
      if (acc_write) begin
        rsp_rdata_d = acc_wdata;
      end else if (in_range) begin
        rsp_rdata_d = mem[acc_idx];
      end else begin
        rsp_rdata_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

  // Array is not reset; gating on rst_n keeps an aborted write from committing.
  always_ff @(posedge clk) begin
    if (rst_n && access && acc_write && in_range) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

`ifdef MEM_RESPONDER_STATS_EN
  logic rsp_hs;
  assign rsp_hs = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (rsp_hs) begin
      if (wr_q) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: instance a (WAIT_CYC=2, DEPTH=128), instance b (WAIT_CYC=0).
// Exercises the stats counters when MEM_RESPONDER_STATS_EN is defined.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic        a_rst_n, a_req_valid, a_req_ready, a_req_write, a_rsp_valid, a_rsp_ready;
  logic [7:0]  a_req_addr;
  logic [31:0] a_req_wdata, a_rsp_rdata;
  logic        b_rst_n, b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready;
  logic [7:0]  b_req_addr;
  logic [31:0] b_req_wdata, b_rsp_rdata;
`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0] a_rd_count, a_wr_count, b_rd_count, b_wr_count;
`endif

  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];

  mem_responder #(.DATA_W(32), .ADDR_W(8), .DEPTH(128), .WAIT_CYC(2)) u_a (
    .clk(clk), .rst_n(a_rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata)
`ifdef MEM_RESPONDER_STATS_EN
    , .rd_count(a_rd_count), .wr_count(a_wr_count)
`endif
  );

  mem_responder #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .WAIT_CYC(0)) u_b (
    .clk(clk), .rst_n(b_rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata)
`ifdef MEM_RESPONDER_STATS_EN
    , .rd_count(b_rd_count), .wr_count(b_wr_count)
`endif
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic fail_timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got timeout, expected DUT event", nm);
  endtask

  // Monitor for instance a: latency, hold stability and response data.
  int unsigned a_acc = 0;
  logic        a_pv = 1'b0;
  logic [31:0] a_prd = '0;
  always @(negedge clk) begin
    if (!a_rst_n) begin
      a_pv <= 1'b0;
    end else begin
      if (a_rsp_valid && !a_pv) check("a_latency", cyc - a_acc, 32'd3);
      if (a_rsp_valid && a_pv) check("a_hold_rdata", a_rsp_rdata, a_prd);
      if (a_rsp_valid && a_rsp_ready) begin
        if (exp_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected_rsp: got rdata %h, expected no response", a_rsp_rdata);
        end else begin
          check("a_rdata", a_rsp_rdata, exp_a.pop_front());
        end
      end
      if (a_req_valid && a_req_ready) a_acc <= cyc;
      a_pv  <= a_rsp_valid;
      a_prd <= a_rsp_rdata;
    end
  end

  // Monitor for instance b: one-cycle latency and two-cycle accept spacing.
  int unsigned b_acc = 0;
  int unsigned b_nacc = 0;
  logic        b_pv = 1'b0;
  always @(negedge clk) begin
    if (!b_rst_n) begin
      b_pv <= 1'b0;
    end else begin
      if (b_rsp_valid && !b_pv) check("b_latency", cyc - b_acc, 32'd1);
      if (b_rsp_valid && b_rsp_ready) begin
        if (exp_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected_rsp: got rdata %h, expected no response", b_rsp_rdata);
        end else begin
          check("b_rdata", b_rsp_rdata, exp_b.pop_front());
        end
      end
      if (b_req_valid && b_req_ready) begin
        if (b_nacc > 0) check("b_accept_spacing", cyc - b_acc, 32'd2);
        b_acc  <= cyc;
        b_nacc <= b_nacc + 1;
      end
      b_pv <= b_rsp_valid;
    end
  end

  task automatic a_wait_accept();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (a_req_valid && a_req_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    fail_timeout("a_accept");
  endtask

  task automatic a_wait_hs();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (a_rsp_valid && a_rsp_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    fail_timeout("a_rsp_handshake");
  endtask

  // Issue one request; after acceptance scramble the request fields, which must be ignored.
  task automatic a_issue(input logic wr, input logic [7:0] addr, input logic [31:0] wd);
    a_req_write = wr;
    a_req_addr  = addr;
    a_req_wdata = wd;
    a_req_valid = 1'b1;
    a_wait_accept();
    a_req_valid = 1'b0;
    a_req_write = ~wr;
    a_req_addr  = 8'hFF;
    a_req_wdata = 32'hBAD0BAD0;
  endtask

  task automatic a_txn(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp);
    exp_a.push_back(exp);
    a_issue(wr, addr, wd);
    a_wait_hs();
  endtask

  task automatic a_reset();
    a_rst_n = 1'b0;
    @(negedge clk);
    check("a_rst_req_ready", {31'd0, a_req_ready}, 32'd0);
    check("a_rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("a_rst_rsp_valid2", {31'd0, a_rsp_valid}, 32'd0);
    check("a_rst_rsp_rdata", a_rsp_rdata, 32'd0);
    @(posedge clk);
    #1;
    a_rst_n = 1'b1;
    @(negedge clk);
    check("a_post_rst_req_ready", {31'd0, a_req_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic b_wait_accept();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b_req_valid && b_req_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    fail_timeout("b_accept");
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  logic        bw[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [7:0]  ba[5] = '{8'h05, 8'h06, 8'h05, 8'h06, 8'h05};
  logic [31:0] bd[5] = '{32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0, 32'h0};
  logic [31:0] be[5] = '{32'h12345678, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0, 32'h12345678};

  initial begin
    bit seen;
    a_rst_n = 1'b0; a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0;
    a_req_wdata = '0; a_rsp_ready = 1'b1;
    b_rst_n = 1'b0; b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0;
    b_req_wdata = '0; b_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("b_rst_rsp_valid", {31'd0, b_rsp_valid}, 32'd0);
    check("b_rst_req_ready", {31'd0, b_req_ready}, 32'd0);
    b_rst_n = 1'b1;
    a_reset();

    // Write then read back with two wait states.
    a_txn(1'b1, 8'h10, 32'hDEADBEEF, 32'hDEADBEEF);
    a_txn(1'b0, 8'h10, 32'h0, 32'hDEADBEEF);

    // Backpressure: response held, next request held off until after the handshake.
    a_rsp_ready = 1'b0;
    exp_a.push_back(32'hDEADBEEF);
    a_req_write = 1'b0; a_req_addr = 8'h10; a_req_valid = 1'b1;
    a_wait_accept();
    a_req_write = 1'b1; a_req_addr = 8'h30; a_req_wdata = 32'h33333333;
    exp_a.push_back(32'h33333333);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = a_rsp_valid;
    end
    if (!seen) fail_timeout("a_bp_rsp_valid");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("a_bp_rsp_valid", {31'd0, a_rsp_valid}, 32'd1);
      check("a_bp_req_ready", {31'd0, a_req_ready}, 32'd0);
      check("a_bp_rdata", a_rsp_rdata, 32'hDEADBEEF);
    end
    @(posedge clk);
    #1;
    a_rsp_ready = 1'b1;
    @(negedge clk);
    check("a_bp_hs_req_ready", {31'd0, a_req_ready}, 32'd0);
    @(negedge clk);
    check("a_bp_next_accept", {31'd0, a_req_ready}, 32'd1);
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    a_wait_hs();
    a_txn(1'b0, 8'h30, 32'h0, 32'h33333333);

    // Reset during WAIT aborts the pending write.
    a_txn(1'b1, 8'h20, 32'h11111111, 32'h11111111);
    a_issue(1'b1, 8'h20, 32'h22222222);
    a_reset();
    a_txn(1'b0, 8'h20, 32'h0, 32'h11111111);

    // Out of range (DEPTH=128): 0x80 must not alias onto word 0.
    a_txn(1'b1, 8'h00, 32'h00000001, 32'h00000001);
    a_txn(1'b1, 8'h80, 32'hAAAA5555, 32'hAAAA5555);
    a_txn(1'b0, 8'h80, 32'h0, 32'h0);
    a_txn(1'b0, 8'h00, 32'h0, 32'h00000001);

    // Zero wait states, back-to-back stream.
    for (int i = 0; i < 5; i++) begin
      b_req_write = bw[i]; b_req_addr = ba[i]; b_req_wdata = bd[i];
      exp_b.push_back(be[i]);
      b_req_valid = 1'b1;
      b_wait_accept();
    end
    b_req_valid = 1'b0;

`ifdef MEM_RESPONDER_STATS_EN
    a_reset();
    check("a_wr_count_rst", {16'd0, a_wr_count}, 32'd0);
    check("a_rd_count_rst", {16'd0, a_rd_count}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      a_txn(1'b1, 8'h40, 32'h00000040, 32'h00000040);
      a_txn(1'b1, 8'h41, 32'h00000041, 32'h00000041);
      a_txn(1'b1, 8'h90, 32'h00000090, 32'h00000090);
      a_txn(1'b0, 8'h40, 32'h0, 32'h00000040);
      a_txn(1'b0, 8'h41, 32'h0, 32'h00000041);
      if (k == 0) begin
        a_issue(1'b1, 8'h42, 32'h00000042);
        a_reset();
        check("a_wr_count_abort", {16'd0, a_wr_count}, 32'd0);
        check("a_rd_count_abort", {16'd0, a_rd_count}, 32'd0);
      end
    end
    @(negedge clk);
    check("a_wr_count", {16'd0, a_wr_count}, 32'd3);
    check("a_rd_count", {16'd0, a_rd_count}, 32'd2);
    check("b_wr_count", {16'd0, b_wr_count}, 32'd2);
    check("b_rd_count", {16'd0, b_rd_count}, 32'd3);
`endif

    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = (exp_a.size() == 0) && (exp_b.size() == 0);
    end
    if (!seen) fail_timeout("drain_scoreboard");
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
